muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_iter.sv | 73 +++++++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op and state encodings for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP   = 3'd6
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add / restoring shift-subtract core
// Works on unsigned magnitudes; acc_hi:acc_lo ends as product, or remainder:quotient.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  state_t           state,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_oper,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] oper;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic             unused_diff_bit;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, oper & {WIDTH{acc_lo[0]}}};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, oper};
    div_ok    = ~div_diff[WIDTH+1];
    hi_next   = acc_hi;
    lo_next   = acc_lo;
    if (state == S_MUL) begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      // Partial remainder stays below the divisor, so W bits always suffice.
      hi_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], div_ok};
    end
  end

  assign unused_diff_bit = div_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      oper   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count  <= CW'(WIDTH);
      acc_hi <= '0;
      acc_lo <= load_lo;
      oper   <= load_oper;
    end else if (count != '0) begin
      count  <= count - CW'(1);
      acc_hi <= hi_next;
      acc_lo <= lo_next;
    end
  end

  assign last = (count == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MUL/DIV unit with HI/LO registers and sign handling
// Controller FSM, operand magnitude/sign capture and final sign correction live here.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             FlushE,
  output logic             Busy,
  output logic             StallReq,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t state, state_next;

  logic               idle;
  logic               issue;
  logic               accept_mul;
  logic               accept_div;
  logic               is_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   saved_a;

  logic [WIDTH-1:0]   it_hi;
  logic [WIDTH-1:0]   it_lo;
  logic               it_last;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               fin_write;

  assign idle       = (state == S_IDLE);
  assign issue      = idle & Start & ~FlushE;
  assign accept_mul = issue & op_is_mul(Op);
  assign accept_div = issue & op_is_div(Op);
  assign is_signed  = SIGNED_EN & op_is_signed(Op);
  assign neg_a      = is_signed & SrcA[WIDTH-1];
  assign neg_b      = is_signed & SrcB[WIDTH-1];
  assign mag_a      = neg_a ? -SrcA : SrcA;
  assign mag_b      = neg_b ? -SrcB : SrcB;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept_mul)      state_next = S_MUL;
        else if (accept_div) state_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (FlushE)       state_next = S_IDLE;
        else if (it_last) state_next = S_FIN;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      saved_a  <= '0;
    end else if (accept_mul | accept_div) begin
      is_div   <= accept_div;
      neg_q    <= neg_a ^ neg_b;
      neg_r    <= neg_a;
      div_zero <= (SrcB == '0);
      saved_a  <= SrcA;
    end
  end

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (CLK),
    .rst      (RST),
    .clear    (FlushE & ~idle),
    .load     (accept_mul | accept_div),
    .state    (state),
    .load_lo  (accept_div ? mag_a : mag_b),
    .load_oper(accept_div ? mag_b : mag_a),
    .acc_hi   (it_hi),
    .acc_lo   (it_lo),
    .last     (it_last)
  );

  // Most-negative / -1 needs no special case: negating 2^(W-1) wraps back to itself.
  always_comb begin
    prod     = {it_hi, it_lo};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = saved_a;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -it_hi : it_hi;
        res_lo = neg_q ? -it_lo : it_lo;
      end
    end
  end

  assign fin_write = (state == S_FIN) & ~FlushE & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      HI <= '0;
      LO <= '0;
    end else if (fin_write) begin
      HI <= res_hi;
      LO <= res_lo;
    end else if (issue && (Op == OP_MTHI)) begin
      HI <= SrcA;
    end else if (issue && (Op == OP_MTLO)) begin
      LO <= SrcA;
    end
  end

  assign Busy     = ~idle;
  assign StallReq = Start & Busy;
  assign Done     = fin_write;

endmodule
